// File: rtl/mem_req_fifo.sv
// Memory request FIFO between the core and the DDR3 shim: 16 x {cmd,addr,dta}
// circular buffer, first-word-fall-through head, sticky overflow on dropped pushes.
module mem_req_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int AF_MARGIN  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [1:0]            wr_cmd,
    input  logic [21:0]           wr_addr,
    input  logic [63:0]           wr_dta,
    output logic                  wr_full,
    output logic                  wr_almost_full,
    input  logic                  mem_req_rd_en,
    output logic                  mem_req_rd_valid,
    output logic [1:0]            mem_req_rd_cmd,
    output logic [21:0]           mem_req_rd_addr,
    output logic [63:0]           mem_req_rd_dta,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int ENTRY_W = 88;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   AF_CNT   = (DEPTH_LOG2+1)'(DEPTH - AF_MARGIN);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO = (DEPTH_LOG2+1)'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = (DEPTH_LOG2)'(0);

    logic [ENTRY_W-1:0]    mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  full_s;
    logic                  push_s;
    logic                  pop_s;
    logic [ENTRY_W-1:0]    head_s;

    // Flags depend only on the registered count, so no strobe-to-flag path exists.
    assign full_s = (count_q == FULL_CNT);
    assign push_s = wr_en & ~full_s;
    assign pop_s  = mem_req_rd_en & (count_q != CNT_ZERO);
    assign head_s = mem_q[rd_ptr_q];

    assign wr_full          = full_s;
    assign wr_almost_full   = (count_q >= AF_CNT);
    assign mem_req_rd_valid = (count_q != CNT_ZERO);
    assign mem_req_rd_cmd   = head_s[87:86];
    assign mem_req_rd_addr  = head_s[85:64];
    assign mem_req_rd_dta   = head_s[63:0];
    assign count            = count_q;
    assign overflow         = overflow_q;

    // Next-state: flush clears everything and wins over push/pop at the same edge.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = PTR_ZERO;
            rd_ptr_d   = PTR_ZERO;
            count_d    = CNT_ZERO;
            overflow_d = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            overflow_d = overflow_q | (wr_en & full_s);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
            count_q    <= CNT_ZERO;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload storage is not reset; head contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (push_s && !flush) begin
            mem_q[wr_ptr_q] <= {wr_cmd, wr_addr, wr_dta};
        end
    end

endmodule

// File: tb/tb_mem_req_fifo.sv
// Self-checking bench for mem_req_fifo: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_mem_req_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_cmd = 2'd0;
    logic [21:0] wr_addr = 22'd0;
    logic [63:0] wr_dta = 64'd0;
    logic        wr_full, wr_almost_full;
    logic        mem_req_rd_en = 1'b0;
    logic        mem_req_rd_valid;
    logic [1:0]  mem_req_rd_cmd;
    logic [21:0] mem_req_rd_addr;
    logic [63:0] mem_req_rd_dta;
    logic [4:0]  count;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [87:0] mq[$];
    logic        m_ovf = 1'b0;

    mem_req_fifo #(.DEPTH_LOG2(4), .AF_MARGIN(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_en(wr_en), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_dta(wr_dta),
        .wr_full(wr_full), .wr_almost_full(wr_almost_full),
        .mem_req_rd_en(mem_req_rd_en), .mem_req_rd_valid(mem_req_rd_valid),
        .mem_req_rd_cmd(mem_req_rd_cmd), .mem_req_rd_addr(mem_req_rd_addr),
        .mem_req_rd_dta(mem_req_rd_dta), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [87:0] obs, input logic [87:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 88'(count), 88'(mq.size()));
        chk({tag, ".valid"}, 88'(mem_req_rd_valid), 88'(mq.size() != 0));
        chk({tag, ".full"}, 88'(wr_full), 88'(mq.size() == 16));
        chk({tag, ".afull"}, 88'(wr_almost_full), 88'(mq.size() >= 14));
        chk({tag, ".ovf"}, 88'(overflow), 88'(m_ovf));
        if (mq.size() != 0) begin
            chk({tag, ".head"}, {mem_req_rd_cmd, mem_req_rd_addr, mem_req_rd_dta}, mq[0]);
        end
    endtask

    // One clock: drive inputs, advance the reference model by the FIFO rules, compare after the edge.
    task automatic cycle(input string tag, input logic we, input logic [1:0] cmd,
                         input logic [21:0] addr, input logic [63:0] dta,
                         input logic re, input logic fl);
        bit was_full;
        bit do_pop;
        wr_en = we; wr_cmd = cmd; wr_addr = addr; wr_dta = dta;
        mem_req_rd_en = re; flush = fl;
        if (fl) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            was_full = (mq.size() == 16);
            do_pop   = re && (mq.size() != 0);
            if (we && was_full) m_ovf = 1'b1;
            if (do_pop) void'(mq.pop_front());
            if (we && !was_full) mq.push_back({cmd, addr, dta});
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; mem_req_rd_en = 1'b0; flush = 1'b0;
        check_all(tag);
    endtask

    initial begin
        // Reset state
        @(posedge clk); #1;
        check_all("reset");
        @(negedge clk); rst_n = 1'b1;

        // Single push into empty, then pop
        cycle("single_push", 1'b1, 2'd3, 22'h123456, 64'hDEADBEEFCAFEBABE, 1'b0, 1'b0);
        cycle("single_pop", 1'b0, 2'd0, 22'd0, 64'd0, 1'b1, 1'b0);
        cycle("empty_pop", 1'b0, 2'd0, 22'd0, 64'd0, 1'b1, 1'b0);

        // Fill with addr 0..15, overflow on 17th, drain in order
        for (int i = 0; i < 16; i++)
            cycle("fill", 1'b1, 2'd2, 22'(i), {$urandom, $urandom}, 1'b0, 1'b0);
        cycle("push17", 1'b1, 2'd3, 22'h3FFFFF, 64'h1111, 1'b0, 1'b0);
        cycle("idle_full", 1'b0, 2'd0, 22'd0, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++)
            cycle("drain", 1'b0, 2'd0, 22'd0, 64'd0, 1'b1, 1'b0);
        cycle("flush_ovf", 1'b0, 2'd0, 22'd0, 64'd0, 1'b0, 1'b1);

        // Full with simultaneous push and pop: pop taken, push dropped
        for (int i = 0; i < 16; i++)
            cycle("fill2", 1'b1, 2'(2 + (i % 2)), 22'($urandom), {$urandom, $urandom}, 1'b0, 1'b0);
        cycle("full_pushpop", 1'b1, 2'd3, 22'h2AAAAA, 64'h5555, 1'b1, 1'b0);
        cycle("flush2", 1'b0, 2'd0, 22'd0, 64'd0, 1'b0, 1'b1);
        cycle("empty_pushpop", 1'b1, 2'd2, 22'h0ABCDE, 64'h0123456789ABCDEF, 1'b1, 1'b0);

        // Count 5, flush with simultaneous push, then a fresh head
        for (int i = 0; i < 4; i++)
            cycle("to5", 1'b1, 2'd3, 22'($urandom), {$urandom, $urandom}, 1'b0, 1'b0);
        cycle("flush_push", 1'b1, 2'd3, 22'h1FFFFF, 64'hFFFF, 1'b1, 1'b1);
        cycle("after_flush", 1'b1, 2'd2, 22'h000042, 64'h42, 1'b0, 1'b0);

        // Random traffic to exercise pointer wrap and ordering
        for (int i = 0; i < 150; i++)
            cycle("rand", 1'($urandom_range(0, 99) < 60), 2'($urandom_range(2, 3)),
                  22'($urandom), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);

        // Asynchronous reset mid-period with 7 entries
        cycle("flush3", 1'b0, 2'd0, 22'd0, 64'd0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++)
            cycle("to7", 1'b1, 2'd3, 22'($urandom), {$urandom, $urandom}, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        check_all("async_rst");
        @(negedge clk); rst_n = 1'b1;
        cycle("post_rst", 1'b1, 2'd2, 22'h155555, 64'hA5A5A5A5A5A5A5A5, 1'b0, 1'b0);
        cycle("post_rst2", 1'b1, 2'd3, 22'h000001, 64'h1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
